part_trgt_chan_bridge: RTL and testbench
========================================

// Module: part_trgt_chan_bridge
// PURPOSE
//  Target-side co-simulation channel bridge; successor to the fixed 3-channel target interface.
//  Detects rising edges on N_CH mission clocks and fetches each channel's download vector over a get handshake.
//  Freezes a channel's mission clock until its vector arrives, then uploads the local result vector over a put handshake.
//  Sits between the SUT wrapper and the fringe transport adapter.
// PARAMETERS
//  N_CH      4      number of mission clock/download channels (2..16)
//  DATA_W    8      payload data width; every vector is {wen/valid, data} = DATA_W+1 bits
//  WDOG_MAX  10000  max consecutive get misses on one channel before error
//  WDOG_W    14     watchdog counter width; must hold WDOG_MAX
// PORTS
//  clk_i      in   1                utility clock, all logic posedge
//  rst_ni     in   1                asynchronous active-low reset
//  mclk_i     in   N_CH             mission clocks, sampled on clk_i
//  get_en_i   in   1                enables get service
//  put_en_i   in   1                enables upload after each service
//  freeze_o   out  N_CH             per-channel mission clock freeze
//  dn_vec_o   out  N_CH*(DATA_W+1)  per-channel {wen,data}; ch k at [k*(DATA_W+1) +: DATA_W+1]
//  up_valid_i in   1                SUT upload valid
//  up_data_i  in   DATA_W           SUT upload data
//  get_req_o  out  1                get request to transport
//  get_ch_o   out  clog2(N_CH)      channel being fetched
//  get_ack_i  in   1                transport answered, one-cycle pulse
//  get_hit_i  in   1                qualifies get_ack_i: payload present
//  get_vec_i  in   DATA_W+1         payload, valid with get_ack_i & get_hit_i
//  put_req_o  out  1                put request to transport
//  put_ch_o   out  clog2(N_CH)      channel tag for the upload
//  put_vec_o  out  DATA_W+1         {up_valid,up_data} captured on entry to SEND
//  put_ack_i  in   1                put accepted, one-cycle pulse
//  overrun_o  out  N_CH             sticky: edge arrived while channel already pending
//  wdog_err_o out  1                sticky watchdog timeout
// BEHAVIOUR
//  Reset: all outputs, pending, state and watchdog go to 0; state = IDLE. dn_vec_o keeps its last value until reset.
//  Edge detect: mclk_d <= mclk_i. Edge on ch k = mclk_i[k] & ~mclk_d[k]. The edge sets pending[k] on the next cycle.
//   If pending[k] is already 1, overrun_o[k] <= 1 instead.
//   Set beats clear: an edge in the same cycle as the service clear leaves pending = 1, with no overrun.
//  Arbiter: round-robin over pending. Search starts at last served channel + 1, with wrap-around at N_CH-1 -> 0.
//  FSM states:
//   IDLE:  if any pending and get_en_i, latch ch, -> GET.
//          Else if any pending and put_en_i, latch ch, clear pending[ch], -> SEND.
//          Else stay.
//   GET:   get_req_o=1, get_ch_o=ch. Request is held until get_ack_i.
//          On ack & hit: dn_vec[ch] <= get_vec_i, freeze_o[ch] <= 0, clear pending[ch], wdog <= 0.
//            Then -> SEND if put_en_i, else IDLE.
//          On ack & ~hit: freeze_o[ch] <= 1, wdog <= wdog+1, -> RETRY.
//   RETRY: get_req_o=0 for exactly one cycle. -> ERR if wdog >= WDOG_MAX, else -> GET.
//   SEND:  put_req_o=1, put_ch_o=ch, put_vec_o stable. Request is held until put_ack_i, then -> IDLE.
//   ERR:   wdog_err_o=1, no requests issued, freeze_o is held. Terminal until rst_ni.
//  Latency: edge seen at cycle t -> pending at t+1 -> get_req_o at t+2 (when idle and no other channel pending).
//  get_ack_i outside GET, and put_ack_i outside SEND, are ignored.
//  get_en_i / put_en_i are sampled only in IDLE and at GET completion; deasserting them mid-handshake does not abort it.
//  Reset mid-handshake: requests drop asynchronously. The transport must discard any outstanding acks.
//  Widths: wdog saturates at WDOG_MAX; it never wraps.
// TESTING
//  1 Reset, then one edge on mclk_i[0], ack+hit with vec=9'h1A5 -> get_req_o at t+2; dn_vec ch0 = 1A5; freeze_o=0.
//  2 Edges on ch1 and ch3 in the same cycle, each serviced by ack+hit -> service order 1 then 3; second order is 3 then 1 when the last served was 1.
//  3 ch2 gets 3 misses, then a hit -> freeze_o[2] goes 1 after the first miss and 0 after the hit; get_req_o low exactly 1 cycle between tries.
//  4 WDOG_MAX=4, four misses -> wdog_err_o=1 and state ERR; no further get_req_o despite new edges.
//  5 put_en_i=1, up_valid_i=1, up_data_i=8'h3C -> put_vec_o=9'h13C; put_req_o is held through 5 stall cycles until put_ack_i.
//  6 Second edge on ch0 while it is pending -> overrun_o[0]=1; an edge coinciding with the clear -> pending re-set, no overrun.

Source files
------------

// File: rtl/part_trgt_chan_bridge.sv
// rtl/part_trgt_chan_bridge.sv - target-side co-sim bridge: mission clock edge detect, get/put channel service
module part_trgt_chan_bridge #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 8,
  parameter int WDOG_MAX = 10000,
  parameter int WDOG_W   = 14
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_CH-1:0]            mclk_i,
  input  logic                       get_en_i,
  input  logic                       put_en_i,
  output logic [N_CH-1:0]            freeze_o,
  output logic [N_CH*(DATA_W+1)-1:0] dn_vec_o,
  input  logic                       up_valid_i,
  input  logic [DATA_W-1:0]          up_data_i,
  output logic                       get_req_o,
  output logic [$clog2(N_CH)-1:0]    get_ch_o,
  input  logic                       get_ack_i,
  input  logic                       get_hit_i,
  input  logic [DATA_W:0]            get_vec_i,
  output logic                       put_req_o,
  output logic [$clog2(N_CH)-1:0]    put_ch_o,
  output logic [DATA_W:0]            put_vec_o,
  input  logic                       put_ack_i,
  output logic [N_CH-1:0]            overrun_o,
  output logic                       wdog_err_o
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int VEC_W = DATA_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET   = 3'd1;
  localparam logic [2:0] S_RETRY = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);

  logic [2:0]        state;
  logic [N_CH-1:0]   mclk_d;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   edge_v;
  logic [N_CH-1:0]   clr;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   last;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic              any_pend;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_inc;
  logic [VEC_W-1:0]  dn_vec [N_CH];

  assign edge_v   = mclk_i & ~mclk_d;
  assign any_pend = |pending;
  assign wdog_inc = (wdog >= WDOG_LIM) ? WDOG_LIM : wdog + 1'b1;

  // Round-robin: first pending channel after the last one served, wrapping.
  always_comb begin
    sel   = last;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CH_W'((int'(last) + i) % N_CH);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state == S_IDLE && any_pend && !get_en_i && put_en_i) clr[sel] = 1'b1;
    if (state == S_GET && get_ack_i && get_hit_i) clr[ch] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      mclk_d    <= '0;
      pending   <= '0;
      overrun_o <= '0;
      freeze_o  <= '0;
      ch        <= '0;
      last      <= '0;
      wdog      <= '0;
      put_vec_o <= '0;
      for (int k = 0; k < N_CH; k++) dn_vec[k] <= '0;
    end else begin
      mclk_d <= mclk_i;
      // A new edge wins over a same-cycle service clear and is not an overrun.
      pending   <= (pending & ~clr) | edge_v;
      overrun_o <= overrun_o | (edge_v & pending & ~clr);
      case (state)
        S_IDLE: begin
          if (any_pend && get_en_i) begin
            ch    <= sel;
            last  <= sel;
            state <= S_GET;
          end else if (any_pend && put_en_i) begin
            ch        <= sel;
            last      <= sel;
            put_vec_o <= {up_valid_i, up_data_i};
            state     <= S_SEND;
          end
        end
        S_GET: begin
          if (get_ack_i) begin
            if (get_hit_i) begin
              dn_vec[ch]   <= get_vec_i;
              freeze_o[ch] <= 1'b0;
              wdog         <= '0;
              if (put_en_i) begin
                put_vec_o <= {up_valid_i, up_data_i};
                state     <= S_SEND;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              freeze_o[ch] <= 1'b1;
              wdog         <= wdog_inc;
              state        <= S_RETRY;
            end
          end
        end
        S_RETRY: state <= (wdog >= WDOG_LIM) ? S_ERR : S_GET;
        S_SEND:  if (put_ack_i) state <= S_IDLE;
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_dn
    assign dn_vec_o[g*VEC_W +: VEC_W] = dn_vec[g];
  end

  assign get_req_o  = (state == S_GET);
  assign get_ch_o   = ch;
  assign put_req_o  = (state == S_SEND);
  assign put_ch_o   = ch;
  assign wdog_err_o = (state == S_ERR);
endmodule

// File: tb/tb_part_trgt_chan_bridge.sv
// tb/tb_part_trgt_chan_bridge.sv - scoreboard bench for part_trgt_chan_bridge
module tb_part_trgt_chan_bridge;
  localparam int N_CH  = 4;
  localparam int DW    = 8;
  localparam int VEC_W = DW + 1;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic [N_CH-1:0]       mclk_i;
  logic                  get_en_i, put_en_i;
  logic [N_CH-1:0]       freeze_o;
  logic [N_CH*VEC_W-1:0] dn_vec_o;
  logic                  up_valid_i;
  logic [DW-1:0]         up_data_i;
  logic                  get_req_o;
  logic [1:0]            get_ch_o;
  logic                  get_ack_i, get_hit_i;
  logic [DW:0]           get_vec_i;
  logic                  put_req_o;
  logic [1:0]            put_ch_o;
  logic [DW:0]           put_vec_o;
  logic                  put_ack_i;
  logic [N_CH-1:0]       overrun_o;
  logic                  wdog_err_o;

  always #5 clk = ~clk;

  part_trgt_chan_bridge #(.N_CH(N_CH), .DATA_W(DW), .WDOG_MAX(4), .WDOG_W(14)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mclk_i(mclk_i), .get_en_i(get_en_i), .put_en_i(put_en_i),
    .freeze_o(freeze_o), .dn_vec_o(dn_vec_o), .up_valid_i(up_valid_i), .up_data_i(up_data_i),
    .get_req_o(get_req_o), .get_ch_o(get_ch_o), .get_ack_i(get_ack_i), .get_hit_i(get_hit_i),
    .get_vec_i(get_vec_i), .put_req_o(put_req_o), .put_ch_o(put_ch_o), .put_vec_o(put_vec_o),
    .put_ack_i(put_ack_i), .overrun_o(overrun_o), .wdog_err_o(wdog_err_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_ch_q[$];
  int exp_put_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [VEC_W-1:0] dn(input int c);
    return dn_vec_o[c*VEC_W +: VEC_W];
  endfunction

  function automatic logic frz(input int c);
    logic [N_CH-1:0] f;
    f = freeze_o;
    return f[c[1:0]];
  endfunction

  task automatic pulse(input logic [N_CH-1:0] m);
    mclk_i = m;
    tick();
    mclk_i = '0;
  endtask

  task automatic wait_get(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (get_req_o) ok = 1'b1;
      else tick();
    end
    if (!ok) check("get_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_get(input bit hit, input logic [DW:0] v);
    get_ack_i = 1'b1;
    get_hit_i = hit;
    get_vec_i = v;
    tick();
    get_ack_i = 1'b0;
    get_hit_i = 1'b0;
  endtask

  task automatic pop_ch(output int c);
    c = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : 0;
    check("get_ch", 32'(get_ch_o), c);
  endtask

  task automatic service(input int misses, input logic [DW:0] v);
    bit ok;
    int c;
    wait_get(ok);
    if (!ok) return;
    pop_ch(c);
    for (int m = 0; m < misses; m++) begin
      ack_get(1'b0, '0);
      check("retry_low", 32'(get_req_o), 32'd0);
      check("freeze_miss", 32'(frz(c)), 32'd1);
      tick();
      check("retry_again", 32'(get_req_o), 32'd1);
    end
    ack_get(1'b1, v);
    check("dn_vec", 32'(dn(c)), 32'(v));
    check("freeze_hit", 32'(frz(c)), 32'd0);
  endtask

  task automatic put_check(input int stalls);
    bit ok;
    int e;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (put_req_o) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      check("put_timeout", 32'd0, 32'd1);
      return;
    end
    e = (exp_put_q.size() > 0) ? exp_put_q.pop_front() : 0;
    check("put_ch", 32'(put_ch_o), e >> 9);
    up_valid_i = ~up_valid_i;
    up_data_i  = ~up_data_i;
    for (int s = 0; s < stalls; s++) begin
      check("put_hold", 32'(put_req_o), 32'd1);
      check("put_vec", 32'(put_vec_o), e & 32'h1FF);
      tick();
    end
    put_ack_i = 1'b1;
    tick();
    put_ack_i = 1'b0;
    check("put_done", 32'(put_req_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int c;
    int cnt;
    rst_ni = 1'b0; mclk_i = '0; get_en_i = 1'b0; put_en_i = 1'b0;
    up_valid_i = 1'b0; up_data_i = '0; get_ack_i = 1'b0; get_hit_i = 1'b0;
    get_vec_i = '0; put_ack_i = 1'b0;
    repeat (3) tick();
    check("rst_get_req", 32'(get_req_o), 32'd0);
    check("rst_put_req", 32'(put_req_o), 32'd0);
    check("rst_freeze", 32'(freeze_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_wdog_err", 32'(wdog_err_o), 32'd0);
    check("rst_dn_vec", 32'(|dn_vec_o), 32'd0);
    check("rst_put_vec", 32'(put_vec_o), 32'd0);
    rst_ni = 1'b1;
    get_en_i = 1'b1;
    tick();

    pulse(4'b0001); exp_ch_q.push_back(0);
    check("lat_t1", 32'(get_req_o), 32'd0);
    tick();
    check("lat_t2", 32'(get_req_o), 32'd1);
    service(0, 9'h1A5);
    check("t1_freeze", 32'(freeze_o), 32'd0);

    pulse(4'b1010); exp_ch_q.push_back(1); exp_ch_q.push_back(3);
    service(0, 9'h011); service(0, 9'h033);
    pulse(4'b0010); exp_ch_q.push_back(1);
    service(0, 9'h0F1);
    pulse(4'b1010); exp_ch_q.push_back(3); exp_ch_q.push_back(1);
    service(0, 9'h1C3); service(0, 9'h12E);

    pulse(4'b0100); exp_ch_q.push_back(2);
    service(3, 9'h0A2);

    put_en_i = 1'b1; up_valid_i = 1'b1; up_data_i = 8'h3C;
    exp_put_q.push_back((0 << 9) | 9'h13C);
    pulse(4'b0001); exp_ch_q.push_back(0);
    service(0, 9'h1E0);
    put_check(5);

    get_en_i = 1'b0; up_valid_i = 1'b0; up_data_i = 8'h55;
    exp_put_q.push_back((1 << 9) | 9'h055);
    pulse(4'b0010);
    put_check(2);
    put_en_i = 1'b0; get_en_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (get_req_o) cnt++;
    end
    check("put_path_cleared", cnt, 32'd0);

    get_en_i = 1'b0;
    pulse(4'b0001); tick();
    pulse(4'b0001); tick();
    check("ovr_set", 32'(overrun_o), 32'h1);
    get_en_i = 1'b1; exp_ch_q.push_back(0);
    service(0, 9'h101);
    pulse(4'b1000); exp_ch_q.push_back(3); exp_ch_q.push_back(3);
    wait_get(ok);
    if (ok) begin
      pop_ch(c);
      mclk_i = 4'b1000;
      ack_get(1'b1, 9'h0B3);
      mclk_i = '0;
      check("coinc_dn_vec", 32'(dn(3)), 32'h0B3);
      check("ovr_none", 32'(overrun_o), 32'h1);
    end
    service(0, 9'h1B3);
    check("ovr_final", 32'(overrun_o), 32'h1);

    pulse(4'b0010); exp_ch_q.push_back(1);
    wait_get(ok);
    if (ok) begin
      pop_ch(c);
      for (int m = 0; m < 4; m++) begin
        ack_get(1'b0, '0);
        check("t4_retry_low", 32'(get_req_o), 32'd0);
        tick();
        check("t4_after_retry", 32'(get_req_o), (m < 3) ? 32'd1 : 32'd0);
      end
    end
    check("wdog_err", 32'(wdog_err_o), 32'd1);
    check("err_freeze", 32'(frz(1)), 32'd1);
    pulse(4'b0100);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (get_req_o || put_req_o) cnt++;
    end
    check("err_no_req", cnt, 32'd0);
    check("err_sticky", 32'(wdog_err_o), 32'd1);
    check("sb_empty", exp_ch_q.size() + exp_put_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
